mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage between EXE and WB in the in-order LoongArch-style core.
- Accepts one instruction per handshake from EXE and waits for the data-bus response on loads.
- Extracts and sign- or zero-extends load data, then presents the completed result to WB.
- Discards late responses belonging to flushed requests, and provides forwarding and stall information to decode.

Parameters:
- CANCEL_W, 2, width of the cancelled-response counter; at most 2**CANCEL_W-1 responses may be outstanding.

Ports:
- clk  in  1  core clock
- resetn  in  1  reset; asynchronous, active-low
- es_to_ms_valid  in  1  EXE holds a valid instruction
- ms_allowin  out  1  MEM can accept this cycle
- es_pc  in  32  instruction PC
- es_gr_we  in  1  writes a GPR
- es_dest  in  5  destination GPR
- es_alu_result  in  32  ALU result or memory address
- es_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW (6 and 7 treated as none)
- es_mem_req  in  1  request accepted by the bus; one data_data_ok will follow
- es_ex  in  1  exception already raised upstream
- es_ecode  in  15  {esubcode, ecode}
- es_req_cancel  in  1  pulse: EXE was flushed after its request was accepted
- data_data_ok  in  1  data response strobe (in-order)
- data_rdata  in  32  response data
- ws_allowin  in  1  WB can accept
- flush  in  1  WB exception, ertn or refetch
- ms_to_ws_valid  out  1  result valid for WB
- ms_pc  out  32  registered PC
- ms_gr_we  out  1  registered gr_we
- ms_dest  out  5  registered dest
- ms_final_result  out  32  load data or ALU result
- ms_ex  out  1  registered es_ex
- ms_ecode  out  15  registered es_ecode
- ms_fwd_dest  out  5  ms_dest when valid and gr_we, else 0
- ms_fwd_data  out  32  equals ms_final_result
- ms_fwd_stall  out  1  valid load still waiting for data
- stall_cnt  out  32  see Optional Feature

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to EMPTY.
  - All registered fields and the cancel counter clear to 0.
  - Resulting outputs: ms_to_ws_valid=0, ms_allowin=1, ms_final_result=0, ms_fwd_dest=0, ms_fwd_stall=0, stall_cnt=0.
  - Reset mid-operation discards everything, including a pending data_data_ok.
- States:
  - EMPTY: no instruction held.
  - WAIT: valid, and es_mem_req was set, and the data has not yet arrived.
  - READY: valid, and the result is complete.
- Accept condition: es_to_ms_valid && ms_allowin && !flush. It latches all es_* fields.
  - Next state is WAIT if es_mem_req, else READY.
- ms_allowin = (state==EMPTY) || (state==READY && ws_allowin).
- ms_to_ws_valid = (state==READY). A result leaves when ws_allowin is high; the stage returns to EMPTY unless a new instruction is accepted in the same cycle.
- WAIT and data response:
  - In WAIT, a data_data_ok with cancel counter == 0 captures data_rdata into a data register and moves to READY next cycle.
  - The response is registered, so there is no combinational path from data_rdata to WB.
- Load extraction from the held word, indexed by addr = ms alu_result:
  - LB / LBU: byte at addr[1:0], sign- or zero-extended.
  - LH / LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
  - Non-load: ms_final_result = alu_result.
  - Alignment is not checked here.
- Flush:
  - flush forces EMPTY next cycle and blocks accept.
  - If the state is WAIT and no data_data_ok arrives in the flush cycle, the cancel counter increments.
- es_req_cancel pulse: increments the cancel counter.
- Response while the cancel counter is non-zero: data_data_ok decrements the counter and the data is dropped; the held state does not change.
- Counter updates:
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Two simultaneous increments (flush in WAIT plus es_req_cancel) add 2.
  - Counter overflow is a protocol violation; it is checked by assertion only.
- ms_fwd_stall = (state==WAIT) && es_load_op latched as a load.

Optional Feature:
- Macro: MEM_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle in which state==WAIT, or state==READY && !ws_allowin.
  - Wraps at 2^32.
  - Not cleared by flush.
- Undefined: stall_cnt is tied to 0 and no counter register is built.

Decomposition:
- Shared package/header holds:
  - load_op encodings (LOAD_NONE, LOAD_LB … LOAD_LW);
  - ecode field width 15;
  - state encodings MS_EMPTY, MS_WAIT, MS_READY.
- One natural sub-module: load_extract, which is combinational. Inputs: 32-bit word, addr[1:0] and load_op. Output: 32-bit result.

Test Plan:
- LB at addr 0x1003, data_rdata=0x80112233, data_data_ok two cycles after accept -> ms_final_result=0xFFFFFF80; ms_fwd_stall high for exactly 2 cycles; ms_to_ws_valid high the following cycle.
- LHU at addr 0x2002, rdata=0xBEEF1234 -> 0x0000BEEF. LW -> 0xBEEF1234. ALU op with result 0x55 -> READY one cycle after accept, with no data_data_ok needed.
- ws_allowin held low 3 cycles while READY -> outputs stable, ms_allowin=0, EXE held; release -> next instruction accepted in the same cycle as departure.
- flush in WAIT, then data_data_ok=0xDEADBEEF, then a new LW with data_data_ok=0x12345678 -> first response discarded; ms_final_result=0x12345678.
- es_req_cancel pulse plus flush in WAIT in the same cycle -> counter=2; the next two responses are dropped and the third is captured.
- resetn asserted low while in WAIT -> all outputs 0 and ms_allowin=1 immediately, without waiting for a clock edge; with MEM_STALL_CNT_EN defined, stall_cnt=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: load-op encodings,
// exception-code width and the stage state encoding.
package mem_stage_pkg;

    localparam int ECODE_W = 15;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_READY = 2'd2
    } ms_state_e;

    // Encodings 6 and 7 are reserved and behave like a non-load.
    function automatic logic is_load(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle around the MEM stage: EXE handshake, data-bus response,
// WB handshake, flush and the forwarding/stall outputs to decode.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                es_to_ms_valid;
    logic                ms_allowin;
    logic [31:0]         es_pc;
    logic                es_gr_we;
    logic [4:0]          es_dest;
    logic [31:0]         es_alu_result;
    logic [2:0]          es_load_op;
    logic                es_mem_req;
    logic                es_ex;
    logic [ECODE_W-1:0]  es_ecode;
    logic                es_req_cancel;
    logic                data_data_ok;
    logic [31:0]         data_rdata;
    logic                ws_allowin;
    logic                flush;
    logic                ms_to_ws_valid;
    logic [31:0]         ms_pc;
    logic                ms_gr_we;
    logic [4:0]          ms_dest;
    logic [31:0]         ms_final_result;
    logic                ms_ex;
    logic [ECODE_W-1:0]  ms_ecode;
    logic [4:0]          ms_fwd_dest;
    logic [31:0]         ms_fwd_data;
    logic                ms_fwd_stall;
    logic [31:0]         stall_cnt;

    modport master (
        output es_to_ms_valid, es_pc, es_gr_we, es_dest, es_alu_result, es_load_op,
               es_mem_req, es_ex, es_ecode, es_req_cancel, data_data_ok, data_rdata,
               ws_allowin, flush,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
               ms_ex, ms_ecode, ms_fwd_dest, ms_fwd_data, ms_fwd_stall, stall_cnt
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_gr_we, es_dest, es_alu_result, es_load_op,
               es_mem_req, es_ex, es_ecode, es_req_cancel, data_data_ok, data_rdata,
               ws_allowin, flush,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
               ms_ex, ms_ecode, ms_fwd_dest, ms_fwd_data, ms_fwd_stall, stall_cnt
    );

endinterface

// File: rtl/mem_stage_chk.sv
// Protocol checker for the MEM stage: the cancelled-response counter
// must never be pushed beyond its range.
module mem_stage_chk (
    input logic clk,
    input logic resetn,
    input logic cancel_overflow
);

    assert property (@(posedge clk) disable iff (!resetn) !cancel_overflow);

endmodule

// File: rtl/mem_stage_load_extract.sv
// Combinational load-data extraction: picks the addressed byte/halfword
// from the held response word and sign- or zero-extends it.
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_op,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the byte and halfword lanes addressed by the low address bits
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (addr[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane according to the load type
    always_comb begin
        result = 32'h0000_0000;
        case (load_op)
            LOAD_LB:  result = {{24{byte_s[7]}}, byte_s};
            LOAD_LBU: result = {24'h00_0000, byte_s};
            LOAD_LH:  result = {{16{half_s[15]}}, half_s};
            LOAD_LHU: result = {16'h0000, half_s};
            LOAD_LW:  result = word;
            default:  result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage (EXE -> MEM -> WB). Holds one instruction, waits for
// the in-order data response on memory requests, drops responses that
// belong to flushed requests, and presents the extended result to WB.
// Optional build macro MEM_STALL_CNT_EN adds a free-running stall counter.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CANCEL_W = 2
)(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);

    localparam int CW2 = CANCEL_W + 2;

    ms_state_e            state_r, state_nxt_s;
    logic [31:0]          pc_r, alu_result_r, data_r;
    logic                 gr_we_r, ex_r;
    logic [4:0]           dest_r;
    logic [2:0]           load_op_r;
    logic [ECODE_W-1:0]   ecode_r;
    logic [CANCEL_W-1:0]  cancel_cnt_r, cancel_nxt_s;
    logic [CW2-1:0]       cnt_calc_s;
    logic                 cancel_overflow_s;
    logic                 allowin_s, accept_s, cnt_zero_s;
    logic                 resp_take_s, resp_drop_s, inc_flush_s;
    logic [31:0]          extract_s, final_s;

    assign allowin_s   = (state_r == MS_EMPTY) || ((state_r == MS_READY) && bus.ws_allowin);
    assign accept_s    = bus.es_to_ms_valid && allowin_s && !bus.flush;
    assign cnt_zero_s  = (cancel_cnt_r == {CANCEL_W{1'b0}});
    assign resp_take_s = bus.data_data_ok && cnt_zero_s && (state_r == MS_WAIT);
    assign resp_drop_s = bus.data_data_ok && !cnt_zero_s;
    // A flushed outstanding request owes one response that must be discarded.
    assign inc_flush_s = bus.flush && (state_r == MS_WAIT) && !bus.data_data_ok;

    // Cancel counter arithmetic, two bits wider so overflow stays visible
    always_comb begin
        cnt_calc_s = {2'b00, cancel_cnt_r}
                   + {{(CW2-1){1'b0}}, inc_flush_s}
                   + {{(CW2-1){1'b0}}, bus.es_req_cancel}
                   - {{(CW2-1){1'b0}}, resp_drop_s};
        cancel_nxt_s      = cnt_calc_s[CANCEL_W-1:0];
        cancel_overflow_s = (cnt_calc_s[CW2-1:CANCEL_W] != 2'b00);
    end

    // Next-state logic: flush wins, otherwise follow the handshakes
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush) begin
            state_nxt_s = MS_EMPTY;
        end else begin
            case (state_r)
                MS_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = bus.es_mem_req ? MS_WAIT : MS_READY;
                    end else begin
                        state_nxt_s = MS_EMPTY;
                    end
                end
                MS_WAIT: begin
                    if (resp_take_s) begin
                        state_nxt_s = MS_READY;
                    end else begin
                        state_nxt_s = MS_WAIT;
                    end
                end
                MS_READY: begin
                    if (accept_s) begin
                        state_nxt_s = bus.es_mem_req ? MS_WAIT : MS_READY;
                    end else if (bus.ws_allowin) begin
                        state_nxt_s = MS_EMPTY;
                    end else begin
                        state_nxt_s = MS_READY;
                    end
                end
                default: state_nxt_s = MS_EMPTY;
            endcase
        end
    end

    // State register and cancelled-response counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= MS_EMPTY;
            cancel_cnt_r <= {CANCEL_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            cancel_cnt_r <= cancel_nxt_s;
        end
    end

    // Latch the instruction fields from EXE on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r         <= 32'h0000_0000;
            gr_we_r      <= 1'b0;
            dest_r       <= 5'd0;
            alu_result_r <= 32'h0000_0000;
            load_op_r    <= 3'd0;
            ex_r         <= 1'b0;
            ecode_r      <= {ECODE_W{1'b0}};
        end else if (accept_s) begin
            pc_r         <= bus.es_pc;
            gr_we_r      <= bus.es_gr_we;
            dest_r       <= bus.es_dest;
            alu_result_r <= bus.es_alu_result;
            load_op_r    <= bus.es_load_op;
            ex_r         <= bus.es_ex;
            ecode_r      <= bus.es_ecode;
        end else begin
            pc_r         <= pc_r;
            gr_we_r      <= gr_we_r;
            dest_r       <= dest_r;
            alu_result_r <= alu_result_r;
            load_op_r    <= load_op_r;
            ex_r         <= ex_r;
            ecode_r      <= ecode_r;
        end
    end

    // Register the live data response so WB never sees data_rdata directly
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_r <= 32'h0000_0000;
        end else if (resp_take_s) begin
            data_r <= bus.data_rdata;
        end else begin
            data_r <= data_r;
        end
    end

    load_extract u_extract (
        .word    (data_r),
        .addr    (alu_result_r[1:0]),
        .load_op (load_op_r),
        .result  (extract_s)
    );

    assign final_s = is_load(load_op_r) ? extract_s : alu_result_r;

    assign bus.ms_allowin      = allowin_s;
    assign bus.ms_to_ws_valid  = (state_r == MS_READY);
    assign bus.ms_pc           = pc_r;
    assign bus.ms_gr_we        = gr_we_r;
    assign bus.ms_dest         = dest_r;
    assign bus.ms_final_result = final_s;
    assign bus.ms_ex           = ex_r;
    assign bus.ms_ecode        = ecode_r;
    assign bus.ms_fwd_dest     = ((state_r != MS_EMPTY) && gr_we_r) ? dest_r : 5'd0;
    assign bus.ms_fwd_data     = final_s;
    assign bus.ms_fwd_stall    = (state_r == MS_WAIT) && is_load(load_op_r);

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Count cycles in which the held instruction cannot move on
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if ((state_r == MS_WAIT) || ((state_r == MS_READY) && !bus.ws_allowin)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`else
    assign bus.stall_cnt = 32'h0000_0000;
`endif

    mem_stage_chk u_chk (
        .clk             (clk),
        .resetn          (resetn),
        .cancel_overflow (cancel_overflow_s)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   n_pass  = 0;
    int   n_total = 0;

    mem_stage_if bus ();

    mem_stage #(.CANCEL_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        mem_req;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.es_to_ms_valid = 1'b0;
        bus.es_pc          = 32'h0;
        bus.es_gr_we       = 1'b0;
        bus.es_dest        = 5'd0;
        bus.es_alu_result  = 32'h0;
        bus.es_load_op     = 3'd0;
        bus.es_mem_req     = 1'b0;
        bus.es_ex          = 1'b0;
        bus.es_ecode       = 15'h0;
        bus.es_req_cancel  = 1'b0;
        bus.data_data_ok   = 1'b0;
        bus.data_rdata     = 32'h0;
        bus.ws_allowin     = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] addr, input logic req,
                           input logic [4:0] dest, input logic [31:0] pc);
        bus.es_to_ms_valid = 1'b1;
        bus.es_load_op     = op;
        bus.es_alu_result  = addr;
        bus.es_mem_req     = req;
        bus.es_dest        = dest;
        bus.es_gr_we       = 1'b1;
        bus.es_pc          = pc;
    endtask

    task automatic drain();
        bus.ws_allowin = 1'b1;
        tick();
        bus.ws_allowin = 1'b0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Reference result from plain shift/mask arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
        h = (w >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd4:    return h;
            3'd5:    return w;
            default: return addr;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        present(v.op, v.addr, v.mem_req, 5'(idx + 1), 32'h1c00_0000 + 32'(idx * 4));
        bus.ws_allowin = 1'b0;
        #1;
        chk($sformatf("vec%0d_allowin", idx), 32'(bus.ms_allowin), 32'd1);
        tick();
        bus.es_to_ms_valid = 1'b0;
        if (v.mem_req) begin
            chk($sformatf("vec%0d_stall_c1", idx), 32'(bus.ms_fwd_stall), 32'(v.op >= 3'd1 && v.op <= 3'd5));
            chk($sformatf("vec%0d_valid_wait", idx), 32'(bus.ms_to_ws_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d_stall_c2", idx), 32'(bus.ms_fwd_stall), 32'(v.op >= 3'd1 && v.op <= 3'd5));
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = v.rdata;
            tick();
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = 32'hA5A5_5A5A;
        end
        chk($sformatf("vec%0d_stall_done", idx), 32'(bus.ms_fwd_stall), 32'd0);
        chk($sformatf("vec%0d_valid", idx), 32'(bus.ms_to_ws_valid), 32'd1);
        chk($sformatf("vec%0d_result", idx), bus.ms_final_result, v.exp);
        chk($sformatf("vec%0d_fwd_data", idx), bus.ms_fwd_data, v.exp);
        chk($sformatf("vec%0d_fwd_dest", idx), 32'(bus.ms_fwd_dest), 32'(idx + 1));
        chk($sformatf("vec%0d_pc", idx), bus.ms_pc, 32'h1c00_0000 + 32'(idx * 4));
        drain();
        chk($sformatf("vec%0d_empty", idx), 32'(bus.ms_to_ws_valid), 32'd0);
    endtask

    // Reference model state
    bit          m_have, m_wait;
    logic [31:0] m_pc, m_alu, m_data, m_stall;
    logic [4:0]  m_dest;
    logic        m_we, m_ex;
    logic [14:0] m_ecode;
    logic [2:0]  m_op;
    bit          q[$];   // outstanding responses in order; 1 = belongs to held instruction

    initial begin
        vecs[0] = '{3'd1, 32'h0000_1003, 32'h8011_2233, 1'b1, 32'hFFFF_FF80};
        vecs[1] = '{3'd2, 32'h0000_1003, 32'h8011_2233, 1'b1, 32'h0000_0080};
        vecs[2] = '{3'd1, 32'h0000_1001, 32'h8011_2233, 1'b1, 32'h0000_0022};
        vecs[3] = '{3'd4, 32'h0000_2002, 32'hBEEF_1234, 1'b1, 32'h0000_BEEF};
        vecs[4] = '{3'd3, 32'h0000_2002, 32'hBEEF_1234, 1'b1, 32'hFFFF_BEEF};
        vecs[5] = '{3'd3, 32'h0000_2000, 32'hBEEF_8234, 1'b1, 32'hFFFF_8234};
        vecs[6] = '{3'd5, 32'h0000_2000, 32'hBEEF_1234, 1'b1, 32'hBEEF_1234};
        vecs[7] = '{3'd0, 32'h0000_0055, 32'h0000_0000, 1'b0, 32'h0000_0055};
        vecs[8] = '{3'd7, 32'h0000_3000, 32'hFFFF_FFFF, 1'b1, 32'h0000_3000};
        vecs[9] = '{3'd2, 32'h0000_1002, 32'h8011_2233, 1'b1, 32'h0000_0011};

        // Reset state
        idle_inputs();
        resetn = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        chk("rst_allowin", 32'(bus.ms_allowin), 32'd1);
        chk("rst_result", bus.ms_final_result, 32'd0);
        chk("rst_fwd_dest", 32'(bus.ms_fwd_dest), 32'd0);
        chk("rst_fwd_stall", 32'(bus.ms_fwd_stall), 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result held stable, next instruction accepted on departure
        present(3'd0, 32'h55, 1'b0, 5'd3, 32'h1c00_0100);
        tick();
        bus.es_alu_result = 32'h66;
        bus.es_dest       = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_allowin", i), 32'(bus.ms_allowin), 32'd0);
            chk($sformatf("bp%0d_result", i), bus.ms_final_result, 32'h55);
            chk($sformatf("bp%0d_valid", i), 32'(bus.ms_to_ws_valid), 32'd1);
            chk($sformatf("bp%0d_fwd_dest", i), 32'(bus.ms_fwd_dest), 32'd3);
            tick();
        end
        bus.ws_allowin = 1'b1;
        #1;
        chk("bp_release_allowin", 32'(bus.ms_allowin), 32'd1);
        tick();
        bus.es_to_ms_valid = 1'b0;
        bus.ws_allowin     = 1'b0;
        chk("bp_next_result", bus.ms_final_result, 32'h66);
        chk("bp_next_valid", 32'(bus.ms_to_ws_valid), 32'd1);
        chk("bp_next_fwd_dest", 32'(bus.ms_fwd_dest), 32'd4);
        drain();

        // Flush in WAIT: the late response is discarded
        present(3'd5, 32'h100, 1'b1, 5'd5, 32'h1c00_0200);
        tick();
        bus.es_to_ms_valid = 1'b0;
        chk("fl_wait_stall", 32'(bus.ms_fwd_stall), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        chk("fl_allowin", 32'(bus.ms_allowin), 32'd1);
        chk("fl_stall", 32'(bus.ms_fwd_stall), 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hDEAD_BEEF;
        tick();
        bus.data_data_ok = 1'b0;
        chk("fl_stale_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        present(3'd5, 32'h104, 1'b1, 5'd6, 32'h1c00_0204);
        tick();
        bus.es_to_ms_valid = 1'b0;
        chk("fl_new_stall", 32'(bus.ms_fwd_stall), 32'd1);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1234_5678;
        tick();
        bus.data_data_ok = 1'b0;
        chk("fl_new_valid", 32'(bus.ms_to_ws_valid), 32'd1);
        chk("fl_new_result", bus.ms_final_result, 32'h1234_5678);
        drain();

        // Cancel pulse plus flush in WAIT: two responses dropped, third captured
        present(3'd5, 32'h200, 1'b1, 5'd8, 32'h1c00_0300);
        tick();
        bus.es_to_ms_valid = 1'b0;
        bus.flush         = 1'b1;
        bus.es_req_cancel = 1'b1;
        tick();
        bus.flush         = 1'b0;
        bus.es_req_cancel = 1'b0;
        present(3'd5, 32'h204, 1'b1, 5'd9, 32'h1c00_0304);
        tick();
        bus.es_to_ms_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = 32'h1111_1111 * 32'(k + 1);
            tick();
            bus.data_data_ok = 1'b0;
            if (k < 2) begin
                chk($sformatf("cc_drop%0d_valid", k), 32'(bus.ms_to_ws_valid), 32'd0);
                chk($sformatf("cc_drop%0d_stall", k), 32'(bus.ms_fwd_stall), 32'd1);
            end else begin
                chk("cc_take_valid", 32'(bus.ms_to_ws_valid), 32'd1);
                chk("cc_take_result", bus.ms_final_result, 32'h3333_3333);
            end
        end
        drain();

        // Randomized run against the reference model
        reset_pulse();
        m_have = 1'b0; m_wait = 1'b0; m_pc = 32'h0; m_alu = 32'h0; m_data = 32'h0;
        m_stall = 32'h0; m_dest = 5'd0; m_we = 1'b0; m_ex = 1'b0; m_ecode = 15'h0; m_op = 3'd0;
        q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic fl, cn, dok, ev, mreq, wsa, e_valid, e_allow, acc;
            fl   = ($urandom_range(0, 15) == 0);
            cn   = fl && ($urandom_range(0, 1) == 1) && (q.size() < 3);
            dok  = !fl && (q.size() > 0) && ($urandom_range(0, 2) != 0);
            ev   = ($urandom_range(0, 3) != 0);
            mreq = ($urandom_range(0, 1) == 1) && (q.size() < 3);
            wsa  = ($urandom_range(0, 3) != 0);
            bus.es_to_ms_valid = ev;
            bus.es_pc          = $urandom;
            bus.es_gr_we       = 1'($urandom_range(0, 1));
            bus.es_dest        = 5'($urandom_range(0, 31));
            bus.es_alu_result  = $urandom;
            bus.es_load_op     = 3'($urandom_range(0, 7));
            bus.es_mem_req     = mreq;
            bus.es_ex          = 1'($urandom_range(0, 1));
            bus.es_ecode       = 15'($urandom_range(0, 32767));
            bus.flush          = fl;
            bus.es_req_cancel  = cn;
            bus.data_data_ok   = dok;
            bus.data_rdata     = $urandom;
            bus.ws_allowin     = wsa;
            #1;
            e_valid = m_have && !m_wait;
            e_allow = !m_have || (e_valid && wsa);
            chk($sformatf("rnd%0d_valid", cyc), 32'(bus.ms_to_ws_valid), 32'(e_valid));
            chk($sformatf("rnd%0d_allowin", cyc), 32'(bus.ms_allowin), 32'(e_allow));
            chk($sformatf("rnd%0d_result", cyc), bus.ms_final_result, ref_result(m_op, m_alu, m_data));
            chk($sformatf("rnd%0d_fwd_dest", cyc), 32'(bus.ms_fwd_dest), (m_have && m_we) ? 32'(m_dest) : 32'd0);
            chk($sformatf("rnd%0d_fwd_stall", cyc), 32'(bus.ms_fwd_stall),
                32'(m_have && m_wait && m_op >= 3'd1 && m_op <= 3'd5));
            chk($sformatf("rnd%0d_pc", cyc), bus.ms_pc, m_pc);
            chk($sformatf("rnd%0d_ecode", cyc), {16'h0, bus.ms_ex, bus.ms_ecode}, {16'h0, m_ex, m_ecode});
`ifdef MEM_STALL_CNT_EN
            chk($sformatf("rnd%0d_stall_cnt", cyc), bus.stall_cnt, m_stall);
            if (m_have && (m_wait || !wsa)) m_stall = m_stall + 32'd1;
`else
            chk($sformatf("rnd%0d_stall_cnt", cyc), bus.stall_cnt, 32'd0);
`endif
            acc = ev && e_allow && !fl;
            if (dok) begin
                if (q.pop_front() && m_have && m_wait) begin
                    m_data = bus.data_rdata;
                    m_wait = 1'b0;
                end
            end
            if (fl) begin
                foreach (q[i]) q[i] = 1'b0;
                m_have = 1'b0;
                m_wait = 1'b0;
                if (cn) q.push_back(1'b0);
            end else begin
                if (e_valid && wsa) m_have = 1'b0;
                if (acc) begin
                    m_have = 1'b1;
                    m_wait = mreq;
                    m_pc = bus.es_pc; m_alu = bus.es_alu_result; m_op = bus.es_load_op;
                    m_dest = bus.es_dest; m_we = bus.es_gr_we; m_ex = bus.es_ex; m_ecode = bus.es_ecode;
                    if (mreq) q.push_back(1'b1);
                end
            end
            tick();
        end

        // Asynchronous reset while waiting for data
        reset_pulse();
        present(3'd5, 32'h400, 1'b1, 5'd7, 32'h1c00_0040);
        bus.es_ex    = 1'b1;
        bus.es_ecode = 15'h1234;
        tick();
        bus.es_to_ms_valid = 1'b0;
        chk("ar_pre_stall", 32'(bus.ms_fwd_stall), 32'd1);
        chk("ar_pre_pc", bus.ms_pc, 32'h1c00_0040);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        chk("ar_allowin", 32'(bus.ms_allowin), 32'd1);
        chk("ar_result", bus.ms_final_result, 32'd0);
        chk("ar_fwd_dest", 32'(bus.ms_fwd_dest), 32'd0);
        chk("ar_fwd_stall", 32'(bus.ms_fwd_stall), 32'd0);
        chk("ar_pc", bus.ms_pc, 32'd0);
        chk("ar_ex_ecode", {16'h0, bus.ms_ex, bus.ms_ecode}, 32'd0);
        chk("ar_stall_cnt", bus.stall_cnt, 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hCAFE_F00D;
        tick();
        bus.data_data_ok = 1'b0;
        resetn = 1'b1;
        tick();
        chk("ar_post_valid", 32'(bus.ms_to_ws_valid), 32'd0);
        chk("ar_post_allowin", 32'(bus.ms_allowin), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
